// File: rtl/bram_burst_reader.sv
// -----------------------------------------------------------------------------
// bram_burst_reader
//
// Read-side burst initiator for the single-port mkBramVerilog memory. A burst
// command (start address, length) is turned into one BRAM read per cycle. Each
// response is captured one cycle later into an internal circular FIFO, which
// the consumer drains with a dequeue strobe. Reads are only issued when the
// FIFO is guaranteed to have room for the response (credit-based issue), so no
// BRAM word is ever dropped, however long the consumer stalls.
//
// Parameters:
//   width   BRAM data width
//   n       BRAM address width
//   lw      burst length field width
//   fdepth  response FIFO depth (power of two, >= 2)
//
// Ports:
//   CLK                   clock, rising edge
//   RST_N                 asynchronous active-low reset
//   START_EN_WRITE        command strobe, accepted only while idle
//   START_ADDR_WRITE      first address of the burst
//   START_LEN_WRITE       number of words in the burst (0 = empty burst)
//   BUSY_READ             burst in progress
//   DONE_READ             one-cycle pulse after the burst's last enqueue
//   BRAM_READ_EN_READ     read issue to BRAM
//   BRAM_READ_REQ_READ    read address to BRAM (holds when not issuing)
//   BRAM_READ_RESP_WRITE  read data from BRAM, valid the cycle after issue
//   DATA_VALID_READ       FIFO non-empty
//   DATA_READ             FIFO head word
//   DATA_DEQ_WRITE        pop FIFO head (ignored when empty)
//   STALL_CNT_READ        saturating count of credit-blocked ISSUE cycles
//                         (only when BRAM_BURST_READER_STALL_CNT_EN is defined)
//
// Optional feature macro: BRAM_BURST_READER_STALL_CNT_EN
// -----------------------------------------------------------------------------
module bram_burst_reader #(
  parameter int width  = 32,
  parameter int n      = 5,
  parameter int lw     = 8,
  parameter int fdepth = 4
) (
  input  logic             CLK,
  input  logic             RST_N,
  input  logic             START_EN_WRITE,
  input  logic [n-1:0]     START_ADDR_WRITE,
  input  logic [lw-1:0]    START_LEN_WRITE,
  output logic             BUSY_READ,
  output logic             DONE_READ,
  output logic             BRAM_READ_EN_READ,
  output logic [n-1:0]     BRAM_READ_REQ_READ,
  input  logic [width-1:0] BRAM_READ_RESP_WRITE,
  output logic             DATA_VALID_READ,
  output logic [width-1:0] DATA_READ,
  input  logic             DATA_DEQ_WRITE
`ifdef BRAM_BURST_READER_STALL_CNT_EN
  ,
  output logic [31:0]      STALL_CNT_READ
`endif
);

  localparam int aw = $clog2(fdepth);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2
  } state_t;

  // ---------------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------------
  state_t          state_q, state_d;
  logic [n-1:0]    addr_q, addr_d;     // next address to issue
  logic [lw-1:0]   rem_q, rem_d;       // reads still to issue
  logic            done_d;
  logic [n-1:0]    req_q;              // last issued address, held on idle
  logic            inflight_q;         // read issued last cycle, data now on RESP

  logic [width-1:0] mem [fdepth];
  logic [aw-1:0]    rd_ptr_q, wr_ptr_q;
  logic [aw:0]      count_q;

  logic enq;
  logic deq_fire;
  logic credit;
  logic issue;

  // ---------------------------------------------------------------------------
  // Credit / issue
  // ---------------------------------------------------------------------------
  assign enq      = inflight_q;
  assign deq_fire = DATA_DEQ_WRITE && (count_q != '0);

  // The slot freed by a same-cycle dequeue counts as credit; without it a
  // depth-2 FIFO could not sustain one word per cycle.
  assign credit = (int'(count_q) + int'(inflight_q) - int'(deq_fire)) < fdepth;
  assign issue  = (state_q == ISSUE) && credit;

  // ---------------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------------
  // NOTE: every output of this block gets a default first so no path leaves a
  // variable unassigned, which would otherwise infer a latch.
  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    rem_d   = rem_q;
    done_d  = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (START_EN_WRITE) begin
          if (START_LEN_WRITE != '0) begin
            addr_d  = START_ADDR_WRITE;
            rem_d   = START_LEN_WRITE;
            state_d = ISSUE;
          end else begin
            // Empty burst: acknowledge without touching the BRAM.
            done_d = 1'b1;
          end
        end
      end
      ISSUE: begin
        if (issue) begin
          addr_d = addr_q + 1'b1;   // wraps modulo 2^n
          rem_d  = rem_q - 1'b1;
          if (rem_q == lw'(1)) begin
            state_d = WAIT;
          end
        end
      end
      WAIT: begin
        // The last read was issued in the previous cycle, so its response is
        // enqueued at this edge.
        if (inflight_q) begin
          state_d = IDLE;
          done_d  = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Control registers
  // ---------------------------------------------------------------------------
  // NOTE: sequential state is updated with non-blocking assignments so every
  // register samples pre-edge values, independent of block ordering.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q    <= IDLE;
      addr_q     <= '0;
      rem_q      <= '0;
      req_q      <= '0;
      inflight_q <= 1'b0;
      DONE_READ  <= 1'b0;
    end else begin
      state_q    <= state_d;
      addr_q     <= addr_d;
      rem_q      <= rem_d;
      inflight_q <= issue;
      DONE_READ  <= done_d;
      if (issue) begin
        req_q <= addr_q;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Response FIFO
  // ---------------------------------------------------------------------------
  // NOTE: the storage array has no reset; occupancy and pointers define which
  // entries are meaningful, and DATA_READ is forced to zero while empty.
  always_ff @(posedge CLK) begin
    if (enq) begin
      mem[wr_ptr_q] <= BRAM_READ_RESP_WRITE;
    end
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (enq) begin
        wr_ptr_q <= wr_ptr_q + 1'b1;   // power-of-two depth wraps naturally
      end
      if (deq_fire) begin
        rd_ptr_q <= rd_ptr_q + 1'b1;
      end
      unique case ({enq, deq_fire})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
    end
  end

`ifdef BRAM_BURST_READER_STALL_CNT_EN
  // ---------------------------------------------------------------------------
  // Stall counter: ISSUE cycles where credit blocked the read. Saturating.
  // ---------------------------------------------------------------------------
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      STALL_CNT_READ <= '0;
    end else if ((state_q == ISSUE) && !credit && (STALL_CNT_READ != '1)) begin
      STALL_CNT_READ <= STALL_CNT_READ + 1'b1;
    end
  end
`endif

  // ---------------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------------
  assign BUSY_READ          = (state_q != IDLE);
  assign BRAM_READ_EN_READ  = issue;
  assign BRAM_READ_REQ_READ = issue ? addr_q : req_q;
  assign DATA_VALID_READ    = (count_q != '0);
  assign DATA_READ          = DATA_VALID_READ ? mem[rd_ptr_q] : '0;

endmodule

// File: tb/tb_bram_burst_reader.sv
// -----------------------------------------------------------------------------
// tb_bram_burst_reader
//
// Scoreboard bench for bram_burst_reader (width=32, n=5, lw=8, fdepth=4).
// A behavioural BRAM (one-cycle read latency, arr[i] = i + 100) answers the
// DUT's reads. Stimulus pushes expected words into a queue as it issues each
// command; an independent monitor pops and compares on every dequeue.
// -----------------------------------------------------------------------------
module tb_bram_burst_reader;

  localparam int width  = 32;
  localparam int n      = 5;
  localparam int lw     = 8;
  localparam int fdepth = 4;

  logic             CLK;
  logic             RST_N;
  logic             START_EN_WRITE;
  logic [n-1:0]     START_ADDR_WRITE;
  logic [lw-1:0]    START_LEN_WRITE;
  logic             BUSY_READ;
  logic             DONE_READ;
  logic             BRAM_READ_EN_READ;
  logic [n-1:0]     BRAM_READ_REQ_READ;
  logic [width-1:0] BRAM_READ_RESP_WRITE;
  logic             DATA_VALID_READ;
  logic [width-1:0] DATA_READ;
  logic             DATA_DEQ_WRITE;
`ifdef BRAM_BURST_READER_STALL_CNT_EN
  logic [31:0]      STALL_CNT_READ;
`endif

  bram_burst_reader #(
    .width (width),
    .n     (n),
    .lw    (lw),
    .fdepth(fdepth)
  ) dut (
    .CLK                 (CLK),
    .RST_N               (RST_N),
    .START_EN_WRITE      (START_EN_WRITE),
    .START_ADDR_WRITE    (START_ADDR_WRITE),
    .START_LEN_WRITE     (START_LEN_WRITE),
    .BUSY_READ           (BUSY_READ),
    .DONE_READ           (DONE_READ),
    .BRAM_READ_EN_READ   (BRAM_READ_EN_READ),
    .BRAM_READ_REQ_READ  (BRAM_READ_REQ_READ),
    .BRAM_READ_RESP_WRITE(BRAM_READ_RESP_WRITE),
    .DATA_VALID_READ     (DATA_VALID_READ),
    .DATA_READ           (DATA_READ),
    .DATA_DEQ_WRITE      (DATA_DEQ_WRITE)
`ifdef BRAM_BURST_READER_STALL_CNT_EN
    ,
    .STALL_CNT_READ      (STALL_CNT_READ)
`endif
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  // Behavioural BRAM: registered read, data valid the cycle after READ_EN.
  logic [width-1:0] arr [1 << n];
  initial begin
    for (int i = 0; i < (1 << n); i++) arr[i] = 32'(i + 100);
  end
  always @(posedge CLK) begin
    if (BRAM_READ_EN_READ) BRAM_READ_RESP_WRITE <= arr[BRAM_READ_REQ_READ];
  end

  // Bookkeeping
  int checks = 0;
  int errors = 0;
  int en_cnt = 0;
  int done_cnt = 0;
  int busy_cnt = 0;
  int pop_cnt = 0;
  logic [width-1:0] sb [$];

  task automatic check(string name, logic [63:0] act, logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", name, act, act, exp, exp);
    end
  endtask

  task automatic timeout(string name);
    checks++;
    errors++;
    $display("FAIL %s: timed out waiting for DUT", name);
  endtask

  // Event counters, sampled mid-cycle.
  always @(negedge CLK) begin
    if (RST_N) begin
      if (BRAM_READ_EN_READ) en_cnt++;
      if (DONE_READ)         done_cnt++;
      if (BUSY_READ)         busy_cnt++;
    end
  end

  // Monitor: every pop that will happen at the next edge is compared here.
  always @(negedge CLK) begin
    if (RST_N && DATA_VALID_READ && DATA_DEQ_WRITE) begin
      pop_cnt++;
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL data_unexpected: got %0d, scoreboard empty", DATA_READ);
      end else begin
        check("data_word", 64'(DATA_READ), 64'(sb.pop_front()));
      end
    end
  end

  // Drives a command; returns 1 ns after the edge that sampled it.
  task automatic cmd(input logic [n-1:0] a, input logic [lw-1:0] l);
    @(posedge CLK); #1;
    START_EN_WRITE   = 1'b1;
    START_ADDR_WRITE = a;
    START_LEN_WRITE  = l;
    @(posedge CLK); #1;
    START_EN_WRITE   = 1'b0;
  endtask

  task automatic set_deq(input logic v);
    @(posedge CLK); #1;
    DATA_DEQ_WRITE = v;
  endtask

  task automatic push_range(input int first, input int cnt);
    for (int i = 0; i < cnt; i++) sb.push_back(32'(first + i));
  endtask

  task automatic wait_done(input int target, input int budget, input string name);
    bit ok = 0;
    for (int i = 0; i < budget; i++) begin
      @(posedge CLK);
      if (done_cnt >= target) begin ok = 1; break; end
    end
    if (!ok) timeout(name);
  endtask

  task automatic drain(input int budget, input string name);
    bit ok = 0;
    for (int i = 0; i < budget; i++) begin
      @(posedge CLK);
      if (sb.size() == 0) begin ok = 1; break; end
    end
    if (!ok) timeout(name);
    repeat (2) @(negedge CLK);
  endtask

  initial begin
    int e0, d0, b0;
    bit found;

    RST_N = 1'b0;
    START_EN_WRITE = 1'b0;
    START_ADDR_WRITE = '0;
    START_LEN_WRITE = '0;
    DATA_DEQ_WRITE = 1'b0;

    // ---- reset state ----
    #12;
    check("rst_busy",  64'(BUSY_READ), 0);
    check("rst_done",  64'(DONE_READ), 0);
    check("rst_en",    64'(BRAM_READ_EN_READ), 0);
    check("rst_req",   64'(BRAM_READ_REQ_READ), 0);
    check("rst_valid", 64'(DATA_VALID_READ), 0);
    check("rst_data",  64'(DATA_READ), 0);
    @(negedge CLK); RST_N = 1'b1;

    // ---- burst ADDR=3 LEN=5, consumer always ready ----
    set_deq(1'b1);
    e0 = en_cnt; d0 = done_cnt;
    push_range(103, 5);
    cmd(5'd3, 8'd5);
    @(negedge CLK);  // between e0 and e1
    check("t1_busy_e0",  64'(BUSY_READ), 1);
    check("t1_en_e0",    64'(BRAM_READ_EN_READ), 1);
    check("t1_req_e0",   64'(BRAM_READ_REQ_READ), 3);
    check("t1_valid_e0", 64'(DATA_VALID_READ), 0);
    @(negedge CLK);  // between e1 and e2
    check("t1_req_e1",   64'(BRAM_READ_REQ_READ), 4);
    check("t1_valid_e1", 64'(DATA_VALID_READ), 0);
    @(negedge CLK);  // after e2: first word present
    check("t1_valid_e2", 64'(DATA_VALID_READ), 1);
    wait_done(d0 + 1, 40, "t1_done");
    drain(40, "t1_drain");
    check("t1_issues", 64'(en_cnt - e0), 5);
    check("t1_dones",  64'(done_cnt - d0), 1);
    check("t1_req_hold", 64'(BRAM_READ_REQ_READ), 7);
`ifdef BRAM_BURST_READER_STALL_CNT_EN
    check("t1_stall_zero", 64'(STALL_CNT_READ), 0);
`endif

    // ---- address wrap: ADDR=30 LEN=4 -> 30,31,0,1 ----
    d0 = done_cnt;
    sb.push_back(32'd130); sb.push_back(32'd131);
    sb.push_back(32'd100); sb.push_back(32'd101);
    cmd(5'd30, 8'd4);
    wait_done(d0 + 1, 40, "t2_done");
    drain(40, "t2_drain");

    // ---- back-pressure: LEN=10 with consumer stalled ----
    set_deq(1'b0);
    e0 = en_cnt; d0 = done_cnt;
    push_range(100, 10);
    cmd(5'd0, 8'd10);
    repeat (20) @(negedge CLK);
    check("t3_issues_full", 64'(en_cnt - e0), 4);
    check("t3_en_stalled",  64'(BRAM_READ_EN_READ), 0);
    check("t3_valid",       64'(DATA_VALID_READ), 1);
    check("t3_busy",        64'(BUSY_READ), 1);
`ifdef BRAM_BURST_READER_STALL_CNT_EN
    check("t3_stall_nonzero", 64'(STALL_CNT_READ != 0), 1);
`endif
    set_deq(1'b1);
    wait_done(d0 + 1, 60, "t3_done");
    drain(40, "t3_drain");
    check("t3_issues_total", 64'(en_cnt - e0), 10);
    check("t3_dones",        64'(done_cnt - d0), 1);

    // ---- zero-length command ----
    e0 = en_cnt; d0 = done_cnt; b0 = busy_cnt;
    cmd(5'd9, 8'd0);
    @(negedge CLK);
    check("t4_done_e1", 64'(DONE_READ), 1);
    check("t4_busy",    64'(BUSY_READ), 0);
    repeat (4) @(negedge CLK);
    check("t4_no_issue",  64'(en_cnt - e0), 0);
    check("t4_one_done",  64'(done_cnt - d0), 1);
    check("t4_never_busy", 64'(busy_cnt - b0), 0);

    // ---- ignored command while busy, then back-to-back in DONE cycle ----
    set_deq(1'b0);
    e0 = en_cnt; d0 = done_cnt;
    push_range(105, 3);
    push_range(110, 2);
    cmd(5'd5, 8'd3);
    cmd(5'd20, 8'd2);   // arrives while busy: must be dropped
    found = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge CLK); #1;
      if (DONE_READ) begin
        START_EN_WRITE   = 1'b1;
        START_ADDR_WRITE = 5'd10;
        START_LEN_WRITE  = 8'd2;
        @(posedge CLK); #1;
        START_EN_WRITE   = 1'b0;
        found = 1;
        break;
      end
    end
    if (!found) timeout("t5_first_done");
    repeat (10) @(negedge CLK);
    check("t5_issues_full", 64'(en_cnt - e0), 4);
    set_deq(1'b1);
    wait_done(d0 + 2, 40, "t5_second_done");
    drain(40, "t5_drain");
    check("t5_issues_total", 64'(en_cnt - e0), 5);
    check("t5_dones",        64'(done_cnt - d0), 2);

    // ---- reset mid-burst with two words queued ----
    set_deq(1'b0);
    cmd(5'd0, 8'd8);
    repeat (3) @(posedge CLK);
    @(negedge CLK);
    check("t6_pre_valid", 64'(DATA_VALID_READ), 1);
    RST_N = 1'b0;
    #1;
    check("t6_rst_busy",  64'(BUSY_READ), 0);
    check("t6_rst_done",  64'(DONE_READ), 0);
    check("t6_rst_en",    64'(BRAM_READ_EN_READ), 0);
    check("t6_rst_req",   64'(BRAM_READ_REQ_READ), 0);
    check("t6_rst_valid", 64'(DATA_VALID_READ), 0);
    check("t6_rst_data",  64'(DATA_READ), 0);
    @(negedge CLK); RST_N = 1'b1;
    @(negedge CLK);
    check("t6_post_valid", 64'(DATA_VALID_READ), 0);
    set_deq(1'b1);
    d0 = done_cnt;
    e0 = pop_cnt;
    sb.push_back(32'd107);
    cmd(5'd7, 8'd1);
    wait_done(d0 + 1, 20, "t6_done");
    drain(20, "t6_drain");
    repeat (4) @(negedge CLK);
    check("t6_pops",  64'(pop_cnt - e0), 1);
    check("sb_empty", 64'(sb.size()), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  // Global watchdog.
  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/bram_burst_reader.md
# bram_burst_reader

Read-side initiator for the single-port `mkBramVerilog` memory. It accepts a burst command (start address and length) and issues one BRAM read per cycle. Each word returned one cycle later is captured into an internal response FIFO, and the consumer drains that FIFO with a dequeue strobe. Credit-based issue guarantees the FIFO never overflows, so BRAM data is never lost regardless of consumer stalls.

## Interface
- `width`, 32, BRAM data width (matches `mkBramVerilog` `width`)
- `n`, 5, BRAM address width
- `lw`, 8, burst length field width
- `fdepth`, 4, response FIFO depth; power of two, at least 2

Ports:
- `CLK`  in  1  clock; everything samples on posedge
- `RST_N`  in  1  reset, asynchronous and active-low
- `START_EN_WRITE`  in  1  command strobe; accepted only when `BUSY_READ`=0
- `START_ADDR_WRITE`  in  n  first address of the burst
- `START_LEN_WRITE`  in  lw  number of words in the burst
- `BUSY_READ`  out  1  burst in progress
- `DONE_READ`  out  1  one-cycle pulse when the last word of a burst is enqueued
- `BRAM_READ_EN_READ`  out  1  read issue, to BRAM `READ_EN_WRITE`
- `BRAM_READ_REQ_READ`  out  n  read address, to BRAM `READ_REQ_WRITE`
- `BRAM_READ_RESP_WRITE`  in  width  BRAM `READ_RESP_READ`
- `DATA_VALID_READ`  out  1  FIFO non-empty
- `DATA_READ`  out  width  FIFO head word
- `DATA_DEQ_WRITE`  in  1  pop the FIFO head; ignored when the FIFO is empty

## Operation
- FSM has three states: `IDLE`, `ISSUE`, `WAIT`.
  - `IDLE`: on `START_EN_WRITE` with LEN>0, latch the address and remaining count, then go to `ISSUE`. With LEN=0, pulse `DONE_READ` next cycle and stay in `IDLE`. While `BUSY_READ`=1, `START_EN_WRITE` is ignored with no side effects.
  - `ISSUE`: in any cycle where credit is available:
    - assert `BRAM_READ_EN_READ` with the current address
    - increment the address modulo 2^n (wraps from 2^n-1 to 0)
    - decrement the remaining count
    - when the last read is issued, go to `WAIT`
  - `WAIT`: when the final response is enqueued, pulse `DONE_READ` and return to `IDLE`.
- Credit rule: issue is allowed iff occupancy + inflight − (`DATA_DEQ_WRITE` & `DATA_VALID_READ`) < `fdepth`.
  - inflight is 0 or 1: a read issued last cycle whose response is captured this cycle.
- Every issued read produces exactly one enqueue, one cycle later, sampled from `BRAM_READ_RESP_WRITE`.
- The FIFO is a circular buffer with read and write pointers plus an occupancy counter. Enqueue and dequeue in the same cycle leave occupancy unchanged.
- FIFO contents persist across bursts. A new burst may start while the FIFO still holds words from the previous one; ordering is preserved.
- `BRAM_READ_REQ_READ` holds its last value when not issuing.
- `BUSY_READ` = (state != `IDLE`).

## Timing
- Reset values, all applied asynchronously on `RST_N` low:
  - `BUSY_READ`=0, `DONE_READ`=0, `BRAM_READ_EN_READ`=0, `BRAM_READ_REQ_READ`=0, `DATA_VALID_READ`=0
  - `DATA_READ`=0
  - FIFO empty, state `IDLE`
- Reset mid-burst discards the burst, any inflight response, and all FIFO contents.
- Command sampled at edge e0 → `BUSY_READ`=1 and the first `BRAM_READ_EN_READ` in cycle e0..e1 → BRAM data is valid and enqueued at e2 → `DATA_VALID_READ`=1 after e2. First-word latency from the command edge is 2 edges.
- Sustained throughput is 1 word/cycle when the consumer dequeues every cycle, for any `fdepth`≥2.
- `DATA_READ` and `DATA_VALID_READ` are driven combinationally from FIFO state (registered storage). A dequeue at edge e updates the head after e.
- `DONE_READ` goes high in the cycle after the final enqueue edge, coinciding with `BUSY_READ` falling. A new `START_EN_WRITE` is accepted in that same cycle.
- If the FIFO is full and there is no dequeue, issue stalls with `BRAM_READ_EN_READ`=0. No response is ever dropped.

## Configuration
- `BRAM_BURST_READER_STALL_CNT_EN`
  - Defined: adds output port `STALL_CNT_READ` (32 bits). It increments in every `ISSUE` cycle where credit blocks issue, saturates at 2^32−1, and resets to 0 only via `RST_N`.
  - Undefined: the port and counter are absent; all other behaviour is identical.

## Test plan
- `fdepth`=4, BRAM preloaded arr[i]=i+100. Command ADDR=3 LEN=5 with DEQ held high → `DATA_READ` shows 103..107 on consecutive cycles. `DONE_READ` pulses once. Stall count stays 0.
- `n`=5. Command ADDR=30 LEN=4 → words from addresses 30, 31, 0, 1 in order.
- Command LEN=10 with DEQ held low → exactly 4 issues, then `BRAM_READ_EN_READ`=0 and `DATA_VALID_READ`=1 with occupancy 4. Then assert DEQ → the remaining 6 words follow with none lost. Stall counter is nonzero.
- Command LEN=0 → no `BRAM_READ_EN_READ`, `DONE_READ` pulses at e1, `BUSY_READ` never rises.
- Second `START_EN_WRITE` while busy → ignored. A back-to-back command issued in the `DONE_READ` cycle → accepted, and its words follow the first burst's words in FIFO order.
- Drop `RST_N` mid-burst with 2 words queued → all outputs are at reset values immediately. After release, a new LEN=1 burst returns only its own word.
